// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared constants and match record type for the score-chain serializer
package sc_pkg;
  localparam int SC_NUM_CH     = 37;
  localparam int SC_TIME_W     = 16;
  localparam int SC_DROP_CNT_W = 16;
  localparam int SC_CH_W       = (SC_NUM_CH > 1) ? $clog2(SC_NUM_CH) : 1;

  typedef struct packed {
    logic [SC_CH_W-1:0]   ch;
    logic [SC_TIME_W-1:0] dt;
  } sc_match_t;
endpackage

// File: rtl/sc_match_serializer_if.sv
// rtl/sc_match_serializer_if.sv - valid/ready match record stream toward the scoring logic
interface sc_match_serializer_if #(
  parameter int NUM_CH = 37,
  parameter int TIME_W = 16
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [TIME_W-1:0] out_dt;

  modport master (output out_valid, output out_ch, output out_dt, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_dt, output out_ready);
endinterface

// File: rtl/sc_rr_arbiter.sv
// rtl/sc_rr_arbiter.sv - round-robin arbiter with internal pointer, one-hot and binary grant
module sc_rr_arbiter #(
  parameter int N = 37
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N-1:0]                        i_req,
  input  logic                                i_en,
  output logic [N-1:0]                        o_gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_gnt_idx,
  output logic                                o_gnt_valid
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_ptr;
  logic [N-1:0] w_gnt;
  logic [W-1:0] w_idx;
  logic         w_found;

  // Scan from the pointer upward with wrap; the first requester wins.
  always_comb begin
    int c;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(r_ptr) + k;
      if (c >= N) c = c - N;
      if (!w_found && i_req[c[W-1:0]]) begin
        w_found          = 1'b1;
        w_idx            = c[W-1:0];
        w_gnt[c[W-1:0]]  = 1'b1;
      end
    end
  end

  assign o_gnt       = w_gnt & {N{i_en}};
  assign o_gnt_idx   = w_idx;
  assign o_gnt_valid = w_found & i_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_valid) begin
      r_ptr <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
    end
  end
endmodule

// File: rtl/sc_match_serializer.sv
// rtl/sc_match_serializer.sv - per-channel match capture and round-robin record serializer
// SC_MATCH_DROP_CNT_EN adds the saturating drop_cnt overrun counter port.
module sc_match_serializer
  import sc_pkg::*;
#(
  parameter int NUM_CH = SC_NUM_CH,
  parameter int TIME_W = SC_TIME_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TIME_W-1:0]        song_time,
  input  logic [NUM_CH-1:0]        match_trigger,
  input  logic [NUM_CH*TIME_W-1:0] match_time,
`ifdef SC_MATCH_DROP_CNT_EN
  output logic [SC_DROP_CNT_W-1:0] drop_cnt,
`endif
  sc_match_serializer_if.master    m_out
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] r_pend;
  logic [TIME_W-1:0] r_dt [NUM_CH];
  logic              r_out_valid;
  logic [CH_W-1:0]   r_out_ch;
  logic [TIME_W-1:0] r_out_dt;

  logic              w_slot_free;
  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_gnt_valid;
  logic [NUM_CH-1:0] w_cap;

  assign w_slot_free = !r_out_valid || m_out.out_ready;

  sc_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (r_pend),
    .i_en        (w_slot_free),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  // A pending channel only re-captures when its old error leaves this cycle.
  assign w_cap = match_trigger & (~r_pend | w_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int i = 0; i < NUM_CH; i++) r_dt[i] <= '0;
    end else begin
      r_pend <= match_trigger | (r_pend & ~w_gnt);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cap[i]) r_dt[i] <= song_time - match_time[i*TIME_W +: TIME_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_dt    <= '0;
    end else if (w_gnt_valid) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= w_gnt_idx;
      r_out_dt    <= r_dt[w_gnt_idx];
    end else if (m_out.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign m_out.out_valid = r_out_valid;
  assign m_out.out_ch    = r_out_ch;
  assign m_out.out_dt    = r_out_dt;

`ifdef SC_MATCH_DROP_CNT_EN
  localparam int OVR_W  = $clog2(NUM_CH + 1);
  localparam int DSUM_W = SC_DROP_CNT_W + 1;

  logic [NUM_CH-1:0]        w_ovr;
  logic [OVR_W-1:0]         w_ovr_cnt;
  logic [DSUM_W-1:0]        w_drop_sum;
  logic [SC_DROP_CNT_W-1:0] r_drop_cnt;

  assign w_ovr = match_trigger & r_pend & ~w_gnt;

  always_comb begin
    w_ovr_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) w_ovr_cnt = w_ovr_cnt + OVR_W'(w_ovr[i]);
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + DSUM_W'(w_ovr_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[SC_DROP_CNT_W]) begin
      r_drop_cnt <= '1;
    end else begin
      r_drop_cnt <= w_drop_sum[SC_DROP_CNT_W-1:0];
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif
endmodule

// File: doc/sc_match_serializer.md
# sc_match_serializer

Parametrised successor to the score-chain buffer serializer. Collects single-cycle match triggers from `NUM_CH` note-buffer channels and computes each match's signed timing error at the trigger moment. Holds one pending error per channel so simultaneous matches are never lost. Emits the errors one at a time to the scoring logic over a valid/ready stream, in round-robin order.

## Interface
- `NUM_CH`, 37: number of note-buffer channels.
- `TIME_W`, 16: width of song time, note time and timing error.
- `CH_W`, `$clog2(NUM_CH)`: width of the channel index. Derived; not overridden.
- `clk` input, 1: the single clock. All logic is on its rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `song_time` input, `TIME_W`: current song time. Free-running; wraps modulo 2^TIME_W.
- `match_trigger` input, `NUM_CH`: bit i is a one-cycle pulse meaning channel i matched a note.
- `match_time` input, `NUM_CH*TIME_W`: slice `[i*TIME_W +: TIME_W]` is channel i's target note time. Sampled only when bit i of `match_trigger` is high.
- `out_valid` output, 1: a match record is presented.
- `out_ready` input, 1: the consumer accepts the record this cycle.
- `out_ch` output, `CH_W`: channel index of the presented record.
- `out_dt` output, `TIME_W`: signed two's-complement error, `song_time - match_time`.
- `drop_cnt` output, 16: overrun counter. Present only with `SC_MATCH_DROP_CNT_EN`.

## Operation
- Capture, per channel i, on a cycle with `match_trigger[i]=1`:
  - `dt_reg[i]` ← `song_time - match_time_i`, computed modulo 2^TIME_W.
  - `pend[i]` ← 1.
- The error is frozen at the trigger cycle. Arbitration delay never changes it.
- Overrun: if `pend[i]=1`, it is not granted this cycle, and `match_trigger[i]=1`, the trigger is discarded. The stored `dt_reg[i]` is kept and `drop_cnt` increments.
- Same-cycle grant and trigger on channel i: the grant takes the old `dt_reg[i]`. The new trigger is captured and `pend[i]` stays 1. This is not a drop.
- Issue: the output slot is free when `!out_valid || out_ready`.
  - When the slot is free and any `pend` bit is set, the arbiter grants one channel.
  - On the grant, `out_ch`, `out_dt` and `out_valid` load from that channel, and its `pend` bit clears.
- Round-robin arbitration:
  - The search starts at `rr_ptr` and proceeds through increasing index, wrapping from `NUM_CH-1` to 0.
  - After a grant to channel g, `rr_ptr` ← g+1, wrapping to 0 after `NUM_CH-1`.
  - A channel pending continuously is granted within `NUM_CH` free slots.
- Handshake:
  - While `out_valid=1 && out_ready=0`, `out_ch` and `out_dt` hold stable.
  - `out_valid` deasserts only after a transfer with no new grant in the same cycle.
- Reset values: all `pend`=0, `dt_reg`=0, `rr_ptr`=0, `out_valid`=0, `out_ch`=0, `out_dt`=0, `drop_cnt`=0.
- Reset asserted mid-operation discards all pending and presented records immediately (asynchronous). Triggers during reset are ignored.

## Timing
- A trigger sampled at edge N sets `pend` at N.
- With no contention and a free slot, `out_valid` rises after edge N+1. Latency is 2 cycles.
- Throughput is one record per cycle while `out_ready=1`. Back-to-back grants need no bubble.
- The grant path is combinational from `pend` and `rr_ptr`. `out_*` are registered; no combinational path from inputs to outputs.
- `out_ready` may toggle freely. A record is accepted exactly once, on the cycle `out_valid && out_ready`.

## Configuration
- `SC_MATCH_DROP_CNT_EN` defined:
  - The `drop_cnt` port and its 16-bit counter exist.
  - The counter increments by the number of channels overrun in that cycle and saturates at 16'hFFFF.
- Not defined: the port and counter are absent. Overruns are silently discarded with the same keep-oldest rule.

## Structure
- Shared package `sc_pkg` holds:
  - The default `TIME_W` and `NUM_CH` constants.
  - The drop-counter width constant.
  - A `sc_match_t` record typedef {ch, dt} reused by downstream scoring.
- Sub-module `sc_rr_arbiter` (parameter `N`) contains the request vector, pointer, one-hot/binary grant and pointer update.
- The top level holds capture registers, the output register and the optional counter.

## Test plan
- Single channel: reset, then `song_time`=100, pulse `match_trigger[0]` with note time 93. Required: `out_valid` two cycles later, `out_ch`=0, `out_dt`=7.
- Signed error with time wrap: `song_time`=16'h0002, channel 5 note time 16'hFFFE. Required: `out_dt`=4. Separately, note time 10 against `song_time`=4 requires `out_dt`=16'hFFFA (−6).
- Simultaneous triggers on channels 36, 0 and 12 with `out_ready`=1 and `rr_ptr`=0. Required order over three consecutive cycles: 0, 12, 36. A further trigger on 0 must then follow 36 in the order.
- Backpressure: hold `out_ready`=0 for 10 cycles with channel 3 presented. Required: `out_ch` and `out_dt` stable throughout. On release, exactly one transfer occurs.
- Overrun: trigger channel 2 twice while blocked by `out_ready`=0. Required: the first dt is delivered and `drop_cnt`=1 with the macro defined. Trigger on the same cycle as its grant: both records are delivered and `drop_cnt` is unchanged.
- Reset mid-stream: assert `rst_n`=0 with 4 channels pending. Required: `out_valid`=0 immediately. After release, no stale records are emitted.
